// File: rtl/down_timer_pkg.sv
// Shared encodings for the loadable 32-bit down-timer: FSM states and the
// byte-select values used by the LED readout.
package down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [1:0] SEL_B0 = 2'd0;
    localparam logic [1:0] SEL_B1 = 2'd1;
    localparam logic [1:0] SEL_B2 = 2'd2;
    localparam logic [1:0] SEL_B3 = 2'd3;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last one as a tick.
// Holds its count while en is low; clr forces it back to zero.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/down_timer32.sv
// Loadable 32-bit down-counter / interval timer with one-shot and auto-reload
// modes, a done pulse at terminal count, and a byte-select LED readout.
module down_timer32
    import down_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        en,
    input  logic        mode,
    input  logic [1:0]  sel,
    output logic [31:0] q,
    output logic [7:0]  led,
    output logic        done,
    output logic        busy
);

    state_t      state;
    logic [31:0] reload;
    logic        tick;
    logic        pre_clr;
    logic        pre_en;

    // Prescaler restarts from zero on every load and whenever the timer is not running.
    assign pre_clr = load || (state != ST_RUN);
    assign pre_en  = en && (state == ST_RUN);

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (pre_clr),
        .en  (pre_en),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            q      <= '0;
            reload <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                q      <= load_val;
                reload <= load_val;
                state  <= ST_IDLE;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (en && (q != 32'd0)) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            // Terminal tick: periodic mode skips zero by reloading directly.
                            if (q == 32'd1) begin
                                done <= 1'b1;
                                if (mode) begin
                                    q <= reload;
                                end else begin
                                    q     <= '0;
                                    state <= ST_EXPIRED;
                                    busy  <= 1'b0;
                                end
                            end else if (q != 32'd0) begin
                                q <= q - 32'd1;
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        q    <= '0;
                        busy <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        led = q[7:0];
        case (sel)
            SEL_B0:  led = q[7:0];
            SEL_B1:  led = q[15:8];
            SEL_B2:  led = q[23:16];
            SEL_B3:  led = q[31:24];
            default: led = q[7:0];
        endcase
    end

endmodule

// File: tb/tb_down_timer32.sv
// Directed bench for down_timer32: a vector table on a PRESCALE=1 instance plus
// hand-written sequences for reset, periodic reload (PRESCALE=4), pause and load/reset races.
module tb_down_timer32;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] load_val;
    logic        en;
    logic        mode;
    logic [1:0]  sel;

    logic [31:0] q1, q4;
    logic [7:0]  led1, led4;
    logic        done1, done4;
    logic        busy1, busy4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    down_timer32 #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
        .mode(mode), .sel(sel), .q(q1), .led(led1), .done(done1), .busy(busy1)
    );

    down_timer32 #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
        .mode(mode), .sel(sel), .q(q4), .led(led4), .done(done4), .busy(busy4)
    );

    typedef struct {
        logic        ld;
        logic [31:0] val;
        logic        en;
        logic        mode;
        logic [1:0]  sel;
        logic [31:0] eq;
        logic [7:0]  eled;
        logic        edone;
        logic        ebusy;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic ld, input logic [31:0] val, input logic e,
                                input logic m, input logic [1:0] s, input logic [31:0] eq,
                                input logic [7:0] eled, input logic ed, input logic eb);
        vec_t v;
        v.ld = ld; v.val = val; v.en = e; v.mode = m; v.sel = s;
        v.eq = eq; v.eled = eled; v.edone = ed; v.ebusy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dones;
        rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; mode = 1'b0; sel = 2'd0;

        // Reset held three edges, then released; enable on a zero count must not start.
        repeat (3) step();
        chk("rst.q", q1, 32'd0);
        chk("rst.led", {24'd0, led1}, 32'd0);
        chk("rst.done", {31'd0, done1}, 32'd0);
        chk("rst.busy", {31'd0, busy1}, 32'd0);
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) step();
        chk("zero_en.busy", {31'd0, busy1}, 32'd0);
        chk("zero_en.q", q1, 32'd0);
        en = 1'b0;

        vecs[0]  = mk(1, 32'd5,        0, 0, 2'd0, 32'd5,        8'h05, 0, 0);
        vecs[1]  = mk(0, 32'd0,        1, 0, 2'd0, 32'd5,        8'h05, 0, 1);
        vecs[2]  = mk(0, 32'd0,        1, 0, 2'd0, 32'd4,        8'h04, 0, 1);
        vecs[3]  = mk(0, 32'd0,        1, 0, 2'd0, 32'd3,        8'h03, 0, 1);
        vecs[4]  = mk(0, 32'd0,        1, 0, 2'd0, 32'd2,        8'h02, 0, 1);
        vecs[5]  = mk(0, 32'd0,        1, 0, 2'd0, 32'd1,        8'h01, 0, 1);
        vecs[6]  = mk(0, 32'd0,        1, 0, 2'd0, 32'd0,        8'h00, 1, 0);
        vecs[7]  = mk(0, 32'd0,        1, 0, 2'd0, 32'd0,        8'h00, 0, 0);
        vecs[8]  = mk(1, 32'hA1B2C3D4, 0, 0, 2'd0, 32'hA1B2C3D4, 8'hD4, 0, 0);
        vecs[9]  = mk(0, 32'd0,        0, 0, 2'd1, 32'hA1B2C3D4, 8'hC3, 0, 0);
        vecs[10] = mk(0, 32'd0,        0, 0, 2'd2, 32'hA1B2C3D4, 8'hB2, 0, 0);
        vecs[11] = mk(0, 32'd0,        0, 0, 2'd3, 32'hA1B2C3D4, 8'hA1, 0, 0);
        vecs[12] = mk(0, 32'd0,        1, 0, 2'd3, 32'hA1B2C3D4, 8'hA1, 0, 1);
        vecs[13] = mk(0, 32'd0,        1, 0, 2'd0, 32'hA1B2C3D3, 8'hD3, 0, 1);
        vecs[14] = mk(1, 32'hFFFFFFFF, 0, 0, 2'd2, 32'hFFFFFFFF, 8'hFF, 0, 0);
        vecs[15] = mk(0, 32'd0,        1, 0, 2'd0, 32'hFFFFFFFF, 8'hFF, 0, 1);
        vecs[16] = mk(0, 32'd0,        1, 0, 2'd0, 32'hFFFFFFFE, 8'hFE, 0, 1);

        for (int i = 0; i < 17; i++) begin
            load = vecs[i].ld; load_val = vecs[i].val; en = vecs[i].en;
            mode = vecs[i].mode; sel = vecs[i].sel;
            step();
            chk($sformatf("v%0d.q", i), q1, vecs[i].eq);
            chk($sformatf("v%0d.led", i), {24'd0, led1}, {24'd0, vecs[i].eled});
            chk($sformatf("v%0d.done", i), {31'd0, done1}, {31'd0, vecs[i].edone});
            chk($sformatf("v%0d.busy", i), {31'd0, busy1}, {31'd0, vecs[i].ebusy});
        end
        load = 1'b0; sel = 2'd0;

        // One-shot expiry then 20 cycles of EXPIRED with en high.
        load = 1'b1; load_val = 32'd2; en = 1'b0; mode = 1'b0; step();
        load = 1'b0; en = 1'b1;
        repeat (3) step();
        chk("exp.q", q1, 32'd0);
        chk("exp.done", {31'd0, done1}, 32'd1);
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("exp_hold%0d.q", k), q1, 32'd0);
            chk($sformatf("exp_hold%0d.busy", k), {31'd0, busy1}, 32'd0);
            chk($sformatf("exp_hold%0d.done", k), {31'd0, done1}, 32'd0);
        end

        // Periodic, PRESCALE=4, reload 3: q=3,2,1,3,... each held 4 cycles; done every 12.
        load = 1'b1; load_val = 32'd3; mode = 1'b1; en = 1'b0; step();
        load = 1'b0; en = 1'b1; step();
        dones = 0;
        for (int k = 0; k <= 36; k++) begin
            if (k > 0) step();
            chk($sformatf("per%0d.q", k), q4, 32'd3 - 32'((k / 4) % 3));
            chk($sformatf("per%0d.done", k), {31'd0, done4},
                {31'd0, (k > 0) && (k % 12 == 0)});
            chk($sformatf("per%0d.busy", k), {31'd0, busy4}, 32'd1);
            if (done4) dones++;
        end
        chk("per.pulses", dones, 3);

        // Pause: dut4 gets 3 enabled cycles (RUN + prescaler at 2), dut1 counts 7->6->5.
        load = 1'b1; load_val = 32'd7; en = 1'b0; mode = 1'b0; step();
        load = 1'b0; en = 1'b1;
        repeat (3) step();
        chk("pause_pre.q4", q4, 32'd7);
        chk("pause_pre.q1", q1, 32'd5);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("pause%0d.q4", k), q4, 32'd7);
            chk($sformatf("pause%0d.busy4", k), {31'd0, busy4}, 32'd1);
        end
        chk("pause.q1", q1, 32'd5);
        en = 1'b1;
        step();
        chk("resume1.q4", q4, 32'd7);
        chk("resume1.q1", q1, 32'd4);
        step();
        chk("resume2.q4", q4, 32'd6);

        // Load coincident with the terminal tick on dut1.
        load = 1'b1; load_val = 32'd2; en = 1'b0; mode = 1'b0; step();
        load = 1'b0; en = 1'b1;
        step();
        step();
        chk("ldterm_pre.q", q1, 32'd1);
        load = 1'b1; load_val = 32'd9;
        step();
        chk("ldterm.q", q1, 32'd9);
        chk("ldterm.done", {31'd0, done1}, 32'd0);
        chk("ldterm.busy", {31'd0, busy1}, 32'd0);
        load = 1'b0; en = 1'b0;
        step();
        chk("ldterm2.done", {31'd0, done1}, 32'd0);
        chk("ldterm2.q", q1, 32'd9);
        en = 1'b1;
        step();
        chk("ldterm_idle.busy", {31'd0, busy1}, 32'd1);
        chk("ldterm_idle.q", q1, 32'd9);

        // Reset mid-RUN.
        step();
        chk("midrun.q", q1, 32'd8);
        rst = 1'b0;
        step();
        chk("rstrun.q1", q1, 32'd0);
        chk("rstrun.led1", {24'd0, led1}, 32'd0);
        chk("rstrun.done1", {31'd0, done1}, 32'd0);
        chk("rstrun.busy1", {31'd0, busy1}, 32'd0);
        chk("rstrun.q4", q4, 32'd0);
        chk("rstrun.busy4", {31'd0, busy4}, 32'd0);
        rst = 1'b1; en = 1'b0;
        step();
        chk("post_rst.q1", q1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
